// File: rtl/bin_bcd.sv
// -----------------------------------------------------------------------------
// bin_bcd -- sequential binary-to-BCD converter (shift-and-add-3 / double-dabble)
//
// Converts a BIN_W-bit binary operand into DIGITS packed BCD digits for the
// 7-segment display path. One binary bit is consumed per clock, so a
// conversion takes BIN_W shift cycles. A one-cycle DONE state follows, and in
// that cycle the result registers update and done pulses.
//
// Ports:
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          asynchronous reset, active low
//   start     in   1          conversion request, honoured only when busy==0
//   bin       in   BIN_W      binary operand, captured on an accepted start
//   bcd       out  4*DIGITS   packed BCD result, digit 0 in [3:0], registered
//   busy      out  1          high while shifting
//   done      out  1          one-cycle pulse; bcd/overflow updated this cycle
//   overflow  out  1          last operand >= 10^DIGITS, registered with bcd
//
// Configuration macro:
//   BIN_BCD_SATURATE_EN  defined   -> an overflowing operand loads all-9s
//                        undefined -> an overflowing operand loads the low
//                                     DIGITS digits of the true value
// -----------------------------------------------------------------------------
module bin_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // One guard digit above the output digits catches every carry. It covers
  // 2^BIN_W-1 as long as that value has at most DIGITS+1 decimal digits.
  localparam int ACC_D = DIGITS + 1;
  localparam int ACC_W = 4 * ACC_D;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q,    state_d;
  logic [BIN_W-1:0]     shift_q,    shift_d;
  logic [ACC_W-1:0]     acc_q,      acc_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [4*DIGITS-1:0]  bcd_q,      bcd_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 overflow_q, overflow_d;

  // Datapath for one double-dabble step.
  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] cat_shifted;
  logic [ACC_W-1:0]       acc_next;
  logic [BIN_W-1:0]       shift_next;
  logic                   ovf_next;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    // Add 3 to any digit >= 5 so that the following doubling carries into
    // the next digit exactly when the decimal digit would exceed 9.
    acc_adj = acc_q;
    for (int i = 0; i < ACC_D; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    cat_shifted = {acc_adj, shift_q} << 1;
    acc_next    = cat_shifted[ACC_W+BIN_W-1:BIN_W];
    shift_next  = cat_shifted[BIN_W-1:0];
    ovf_next    = |acc_next[ACC_W-1:4*DIGITS];

    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back
      // conversions at one per BIN_W+1 cycles.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shift_d = bin;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        acc_d   = acc_next;
        shift_d = shift_next;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Last bit: results load on the same edge that enters DONE, so
          // they are already valid while done is high.
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          overflow_d = ovf_next;
`ifdef BIN_BCD_SATURATE_EN
          bcd_d      = ovf_next ? {DIGITS{4'h9}} : acc_next[4*DIGITS-1:0];
`else
          bcd_d      = acc_next[4*DIGITS-1:0];
`endif
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bcd      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_bcd.sv
// -----------------------------------------------------------------------------
// tb_bin_bcd -- directed self-checking bench for bin_bcd (BIN_W=14, DIGITS=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bin_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int lat;
  int done_cnt;

  bin_bcd #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge. Drives a one-cycle start, then waits (bounded)
  // for done. lat counts cycles after the accepting edge, so done arrives at
  // lat=15; busy_cnt counts sampled busy cycles before done.
  task automatic do_conv(input logic [13:0] v, output int b_cnt, output int l);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'h3fff;   // operand changes mid-conversion must not matter
    l     = 1;
    b_cnt = 0;
    while (done !== 1'b1 && l < 40) begin
      if (busy === 1'b1) b_cnt++;
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    check("reset_bcd",      bcd,      32'h0);
    check("reset_busy",     busy,     32'h0);
    check("reset_done",     done,     32'h0);
    check("reset_overflow", overflow, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic conversion with latency and busy length
    do_conv(14'd1234, busy_cnt, lat);
    check("t1_latency",  lat,      15);
    check("t1_busy_cyc", busy_cnt, 14);
    check("t1_bcd",      bcd,      32'h1234);
    check("t1_overflow", overflow, 32'h0);
    check("t1_done_busy", busy,    32'h0);
    @(negedge clk);
    check("t1_done_pulse", done,   32'h0);
    check("t1_bcd_hold",   bcd,    32'h1234);

    // 2: zero and the largest in-range value
    do_conv(14'd0, busy_cnt, lat);
    check("t2_zero_latency", lat, 15);
    check("t2_zero_bcd",     bcd, 32'h0000);
    check("t2_zero_ovf",     overflow, 32'h0);
    @(negedge clk);
    do_conv(14'd9999, busy_cnt, lat);
    check("t2_9999_bcd", bcd,      32'h9999);
    check("t2_9999_ovf", overflow, 32'h0);
    @(negedge clk);

    // 3: overflowing operands
    do_conv(14'd10000, busy_cnt, lat);
`ifdef BIN_BCD_SATURATE_EN
    check("t3_10000_bcd", bcd, 32'h9999);
`else
    check("t3_10000_bcd", bcd, 32'h0000);
`endif
    check("t3_10000_ovf", overflow, 32'h1);
    @(negedge clk);
    do_conv(14'd16383, busy_cnt, lat);
`ifdef BIN_BCD_SATURATE_EN
    check("t3_16383_bcd", bcd, 32'h9999);
`else
    check("t3_16383_bcd", bcd, 32'h6383);
`endif
    check("t3_16383_ovf", overflow, 32'h1);
    @(negedge clk);

    // 4: start while busy is ignored
    start = 1'b1;
    bin   = 14'd42;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (4) begin @(negedge clk); lat++; end
    start = 1'b1;                // cycle 5
    bin   = 14'd777;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("t4_latency",  lat,      15);
    check("t4_bcd",      bcd,      32'h0042);
    check("t4_overflow", overflow, 32'h0);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("t4_no_extra_done", done_cnt, 0);
    check("t4_bcd_hold",      bcd,      32'h0042);

    // 5: back-to-back start issued in the done cycle
    do_conv(14'd56, busy_cnt, lat);
    check("t5_first_bcd", bcd, 32'h0056);
    do_conv(14'd8080, busy_cnt, lat);
    check("t5_second_latency", lat,      15);
    check("t5_second_busy",    busy_cnt, 14);
    check("t5_second_bcd",     bcd,      32'h8080);
    @(negedge clk);

    // 6: reset mid-conversion
    start = 1'b1;
    bin   = 14'd4321;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);   // cycle 7
    rst_n = 1'b0;
    #1;
    check("t6_rst_bcd",  bcd,      32'h0);
    check("t6_rst_busy", busy,     32'h0);
    check("t6_rst_done", done,     32'h0);
    check("t6_rst_ovf",  overflow, 32'h0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("t6_no_done_after_abort", done_cnt, 0);
    do_conv(14'd5, busy_cnt, lat);
    check("t6_post_latency", lat, 15);
    check("t6_post_bcd",     bcd, 32'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
